// File: rtl/shift_reg_universal_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_universal_if
//  Purpose  : Control, data and status bundle for shift_reg_universal.
//  Revision : 1.0  initial release
// ============================================================================
interface shift_reg_universal_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             en;
    logic [1:0]       mode;
    logic             d_sin;
    logic [WIDTH-1:0] d_pin;
    logic [WIDTH-1:0] q;
    logic             d_sout;
    logic [CNT_W-1:0] bit_cnt;
    logic             frame_valid;

    modport master (
        output en, mode, d_sin, d_pin,
        input  q, d_sout, bit_cnt, frame_valid
    );

    modport slave (
        input  en, mode, d_sin, d_pin,
        output q, d_sout, bit_cnt, frame_valid
    );
endinterface
`default_nettype wire

// File: rtl/shift_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_universal
//  Purpose  : Universal shift register (SIPO/PISO, both directions, load,
//             hold) with frame bit counter and one-cycle frame_valid strobe.
//  Revision : 1.0  initial release
// ============================================================================
module shift_reg_universal #(
    parameter int WIDTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    shift_reg_universal_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0]       c_MODE_RIGHT = 2'b01;
    localparam logic [1:0]       c_MODE_LEFT  = 2'b10;
    localparam logic [1:0]       c_MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_frame_valid;

    logic             w_load;
    logic             w_shift;
    logic [WIDTH-1:0] w_shift_q;
    logic             w_frame_done;

    // Mode 00 and the load mode fall through to "no shift"; load is decoded separately.
    always_comb begin
        w_shift   = 1'b0;
        w_shift_q = r_q;
        case (bus.mode)
            c_MODE_RIGHT: begin
                w_shift   = bus.en;
                w_shift_q = {bus.d_sin, r_q[WIDTH-1:1]};
            end
            c_MODE_LEFT: begin
                w_shift   = bus.en;
                w_shift_q = {r_q[WIDTH-2:0], bus.d_sin};
            end
            default: begin
                w_shift   = 1'b0;
                w_shift_q = r_q;
            end
        endcase
    end

    assign w_load       = (bus.mode == c_MODE_LOAD);
    assign w_frame_done = w_shift && (r_bit_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q           <= '0;
            r_bit_cnt     <= '0;
            r_frame_valid <= 1'b0;
        end else if (w_load) begin
            r_q           <= bus.d_pin;
            r_bit_cnt     <= '0;
            r_frame_valid <= 1'b0;
        end else if (w_shift) begin
            r_q           <= w_shift_q;
            r_bit_cnt     <= w_frame_done ? '0 : r_bit_cnt + CNT_W'(1);
            r_frame_valid <= w_frame_done;
        end else begin
            r_frame_valid <= 1'b0;
        end
    end

    // Serial out is the bit that leaves on the next shift edge in the selected direction.
    assign bus.d_sout      = (bus.mode == c_MODE_LEFT) ? r_q[WIDTH-1] : r_q[0];
    assign bus.q           = r_q;
    assign bus.bit_cnt     = r_bit_cnt;
    assign bus.frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_universal.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_reg_universal
//  Purpose  : Directed self-checking bench for shift_reg_universal (W=4, W=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_reg_universal;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    shift_reg_universal_if #(.WIDTH(4)) bus4 ();
    shift_reg_universal_if #(.WIDTH(8)) bus8 ();

    shift_reg_universal #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    shift_reg_universal #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift4(input string tag, input logic d, input logic [3:0] eq,
                          input logic [1:0] ec, input logic ef);
        bus4.d_sin = d;
        tick();
        check_eq({tag, ".q"},  32'(bus4.q),           32'(eq));
        check_eq({tag, ".cnt"}, 32'(bus4.bit_cnt),    32'(ec));
        check_eq({tag, ".fv"}, 32'(bus4.frame_valid), 32'(ef));
    endtask

    initial begin
        logic [7:0] pat8;
        pat8 = 8'b0100_1101;

        rst        = 1'b0;
        bus4.mode  = 2'b01;
        bus4.en    = 1'b1;
        bus4.d_sin = 1'b1;
        bus4.d_pin = 4'b0000;
        bus8.mode  = 2'b00;
        bus8.en    = 1'b0;
        bus8.d_sin = 1'b0;
        bus8.d_pin = 8'h00;

        // Reset overrides an active shift request
        tick();
        tick();
        check_eq("rst.q",    32'(bus4.q),           32'h0);
        check_eq("rst.cnt",  32'(bus4.bit_cnt),     32'h0);
        check_eq("rst.fv",   32'(bus4.frame_valid), 32'h0);
        check_eq("rst.q8",   32'(bus8.q),           32'h0);
        check_eq("rst.cnt8", 32'(bus8.bit_cnt),     32'h0);

        // Shift right 1,0,1,1
        rst = 1'b1;
        shift4("sr1", 1'b1, 4'b1000, 2'd1, 1'b0);
        shift4("sr2", 1'b0, 4'b0100, 2'd2, 1'b0);
        shift4("sr3", 1'b1, 4'b1010, 2'd3, 1'b0);
        shift4("sr4", 1'b1, 4'b1101, 2'd0, 1'b1);
        bus4.mode = 2'b00;
        tick();
        check_eq("hold.q",  32'(bus4.q),           32'hD);
        check_eq("hold.fv", 32'(bus4.frame_valid), 32'h0);

        // Clear via load, then shift left 1,0,1,1
        bus4.mode  = 2'b11;
        bus4.d_pin = 4'b0000;
        tick();
        check_eq("clr.q", 32'(bus4.q), 32'h0);
        bus4.mode = 2'b10;
        check_eq("sl.sout0", 32'(bus4.d_sout), 32'h0);
        shift4("sl1", 1'b1, 4'b0001, 2'd1, 1'b0);
        shift4("sl2", 1'b0, 4'b0010, 2'd2, 1'b0);
        shift4("sl3", 1'b1, 4'b0101, 2'd3, 1'b0);
        shift4("sl4", 1'b1, 4'b1011, 2'd0, 1'b1);
        check_eq("sl.sout4", 32'(bus4.d_sout), 32'h1);

        // Parallel load ignores en, then serialise out to the right
        bus4.mode  = 2'b11;
        bus4.en    = 1'b0;
        bus4.d_pin = 4'b1001;
        tick();
        check_eq("ld.q",   32'(bus4.q),           32'h9);
        check_eq("ld.cnt", 32'(bus4.bit_cnt),     32'h0);
        check_eq("ld.fv",  32'(bus4.frame_valid), 32'h0);
        bus4.en   = 1'b1;
        bus4.mode = 2'b01;
        check_eq("piso.sout1", 32'(bus4.d_sout), 32'h1);
        shift4("piso1", 1'b0, 4'b0100, 2'd1, 1'b0);
        check_eq("piso.sout2", 32'(bus4.d_sout), 32'h0);
        shift4("piso2", 1'b0, 4'b0010, 2'd2, 1'b0);
        check_eq("piso.sout3", 32'(bus4.d_sout), 32'h0);
        shift4("piso3", 1'b0, 4'b0001, 2'd3, 1'b0);
        check_eq("piso.sout4", 32'(bus4.d_sout), 32'h1);
        shift4("piso4", 1'b0, 4'b0000, 2'd0, 1'b1);

        // Enable gap mid-frame
        shift4("gap1", 1'b1, 4'b1000, 2'd1, 1'b0);
        shift4("gap2", 1'b1, 4'b1100, 2'd2, 1'b0);
        bus4.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("gap.hold.q",   32'(bus4.q),           32'hC);
            check_eq("gap.hold.cnt", 32'(bus4.bit_cnt),     32'h2);
            check_eq("gap.hold.fv",  32'(bus4.frame_valid), 32'h0);
        end
        bus4.en = 1'b1;
        shift4("gap3", 1'b0, 4'b0110, 2'd3, 1'b0);
        shift4("gap4", 1'b0, 4'b0011, 2'd0, 1'b1);

        // Reset mid-frame beats a load request and discards the partial frame
        shift4("mid1", 1'b1, 4'b1001, 2'd1, 1'b0);
        shift4("mid2", 1'b1, 4'b1100, 2'd2, 1'b0);
        rst        = 1'b0;
        bus4.mode  = 2'b11;
        bus4.d_pin = 4'b1111;
        tick();
        check_eq("midrst.q",   32'(bus4.q),       32'h0);
        check_eq("midrst.cnt", 32'(bus4.bit_cnt), 32'h0);
        rst       = 1'b1;
        bus4.mode = 2'b01;
        shift4("post1", 1'b1, 4'b1000, 2'd1, 1'b0);
        shift4("post2", 1'b1, 4'b1100, 2'd2, 1'b0);
        shift4("post3", 1'b1, 4'b1110, 2'd3, 1'b0);
        shift4("post4", 1'b1, 4'b1111, 2'd0, 1'b1);

        // Direction changes mid-frame keep counting
        bus4.mode = 2'b10;
        shift4("dir1", 1'b0, 4'b1110, 2'd1, 1'b0);
        bus4.mode = 2'b01;
        shift4("dir2", 1'b0, 4'b0111, 2'd2, 1'b0);
        bus4.mode = 2'b10;
        shift4("dir3", 1'b1, 4'b1111, 2'd3, 1'b0);
        bus4.mode = 2'b01;
        shift4("dir4", 1'b0, 4'b0111, 2'd0, 1'b1);
        bus4.mode = 2'b00;

        // WIDTH=8 frame: bits 1,0,1,1,0,0,1,0 shifted right
        bus8.mode = 2'b01;
        bus8.en   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus8.d_sin = pat8[i];
            tick();
            if (i == 3) begin
                check_eq("w8.q4",   32'(bus8.q),           32'hD0);
                check_eq("w8.cnt4", 32'(bus8.bit_cnt),     32'h4);
                check_eq("w8.fv4",  32'(bus8.frame_valid), 32'h0);
            end
            if (i == 6) begin
                check_eq("w8.cnt7", 32'(bus8.bit_cnt),     32'h7);
                check_eq("w8.fv7",  32'(bus8.frame_valid), 32'h0);
            end
        end
        check_eq("w8.q8",   32'(bus8.q),           32'h4D);
        check_eq("w8.cnt8", 32'(bus8.bit_cnt),     32'h0);
        check_eq("w8.fv8",  32'(bus8.frame_valid), 32'h1);
        bus8.mode = 2'b00;
        tick();
        check_eq("w8.fvoff", 32'(bus8.frame_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
